keypad_time_entry: RTL and testbench



---
 rtl/keypad_time_entry_if.sv | 22 ++
 rtl/keypad_time_entry.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_time_entry_if.sv
// Keypad matrix and time-set signal bundle between the keypad entry block and its neighbours.
// The master side scans the keypad and publishes entered/loaded values; the slave side sees them.
interface keypad_time_entry_if;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [7:0]  Hour;
    logic [7:0]  Minutes;
    logic        Load;
    logic [15:0] Entry;
    logic [2:0]  DigitCnt;
    logic        Error;

    modport master (
        input  Row,
        output Col, Hour, Minutes, Load, Entry, DigitCnt, Error
    );

    modport slave (
        output Row,
        input  Col, Hour, Minutes, Load, Entry, DigitCnt, Error
    );
endinterface

// File: rtl/keypad_time_entry.sv
// 4x4 keypad scanner with frame debounce and HHMM BCD entry; emits a one-cycle Load with
// the accepted Hour/Minutes on a valid '#', clears on '*'.
module keypad_time_entry #(
    parameter int CLK_Freq  = 50000000,
    parameter int SCAN_Freq = 1000,
    parameter int DEBOUNCE  = 20
) (
    input  logic                 CP50,
    input  logic                 nCR,
    keypad_time_entry_if.master  bus
);

    localparam int TICK_DIV = CLK_Freq / SCAN_Freq;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W     = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;

    typedef enum logic {DB_RELEASED, DB_PRESSED} db_state_t;
    typedef enum logic [1:0] {EN_IDLE, EN_ENTRY, EN_FULL} en_state_t;

    // Number of active-low rows in one sample.
    function automatic logic [2:0] low_count(input logic [3:0] row);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, ~row[i]};
        return n;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) if (!row[i]) idx = 2'(i);
        return idx;
    endfunction

    // Frame low count only needs to distinguish 0, 1 and "two or more".
    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [2:0] b);
        logic [2:0] s;
        s = {1'b0, a} + b;
        return (s >= 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Key code {row,col} -> {is_digit, BCD value}; letters and '*'/'#' are not digits.
    function automatic logic [4:0] key_digit(input logic [3:0] code);
        case (code)
            4'd0:    return 5'h11;
            4'd1:    return 5'h12;
            4'd2:    return 5'h13;
            4'd4:    return 5'h14;
            4'd5:    return 5'h15;
            4'd6:    return 5'h16;
            4'd8:    return 5'h17;
            4'd9:    return 5'h18;
            4'd10:   return 5'h19;
            4'd13:   return 5'h10;
            default: return 5'h00;
        endcase
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       nlow_q, nlow_d;
    logic [3:0]       fkey_q, fkey_d;
    db_state_t        db_state_q, db_state_d;
    logic [3:0]       cand_q, cand_d;
    logic             cand_vld_q, cand_vld_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             evt_q, evt_d;
    logic [3:0]       evt_key_q, evt_key_d;
    en_state_t        en_state_q, en_state_d;
    logic [15:0]      entry_q, entry_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       hour_q, hour_d;
    logic [7:0]       min_q, min_d;
    logic             load_q, load_d;

    logic       tick, frame_end;
    logic [2:0] row_lows;
    logic [1:0] frame_lows;
    logic [3:0] samp_code, frame_code;
    logic [4:0] key_dig;
    logic       hour_ok;

    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            div_q      <= '0;
            col_q      <= 2'd0;
            nlow_q     <= 2'd0;
            fkey_q     <= 4'd0;
            db_state_q <= DB_RELEASED;
            cand_q     <= 4'd0;
            cand_vld_q <= 1'b0;
            db_cnt_q   <= '0;
            evt_q      <= 1'b0;
            evt_key_q  <= 4'd0;
            en_state_q <= EN_IDLE;
            entry_q    <= 16'h0000;
            cnt_q      <= 3'd0;
            err_q      <= 1'b0;
            hour_q     <= 8'h00;
            min_q      <= 8'h00;
            load_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            col_q      <= col_d;
            nlow_q     <= nlow_d;
            fkey_q     <= fkey_d;
            db_state_q <= db_state_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            db_cnt_q   <= db_cnt_d;
            evt_q      <= evt_d;
            evt_key_q  <= evt_key_d;
            en_state_q <= en_state_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            load_q     <= load_d;
        end
    end

    // Scan, frame accumulation and debounce.
    always_comb begin
        tick       = (div_q == DIV_MAX);
        div_d      = tick ? '0 : div_q + 1'b1;
        col_d      = tick ? col_q + 2'd1 : col_q;
        row_lows   = low_count(bus.Row);
        frame_lows = sat_add(nlow_q, row_lows);
        frame_end  = tick && (col_q == 2'd3);
        samp_code  = {low_index(bus.Row), col_q};
        frame_code = (row_lows == 3'd1) ? samp_code : fkey_q;

        nlow_d = nlow_q;
        fkey_d = fkey_q;
        if (tick) begin
            nlow_d = frame_end ? 2'd0 : frame_lows;
            if (row_lows == 3'd1) fkey_d = samp_code;
        end

        db_state_d = db_state_q;
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        db_cnt_d   = db_cnt_q;
        evt_d      = 1'b0;
        evt_key_d  = evt_key_q;
        if (frame_end) begin
            case (db_state_q)
                DB_RELEASED: begin
                    if (frame_lows == 2'd1) begin
                        if (cand_vld_q && cand_q == frame_code) begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end else begin
                            cand_d     = frame_code;
                            cand_vld_d = 1'b1;
                            db_cnt_d   = DB_W'(1);
                        end
                        if (db_cnt_d == DB_MAX) begin
                            db_state_d = DB_PRESSED;
                            db_cnt_d   = '0;
                            cand_vld_d = 1'b0;
                            evt_d      = 1'b1;
                            evt_key_d  = frame_code;
                        end
                    end else begin
                        cand_vld_d = 1'b0;
                        db_cnt_d   = '0;
                    end
                end
                default: begin
                    if (frame_lows != 2'd1) begin
                        db_cnt_d = db_cnt_q + 1'b1;
                        if (db_cnt_d == DB_MAX) begin
                            db_state_d = DB_RELEASED;
                            db_cnt_d   = '0;
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Entry FSM next state: acts on the registered key event.
    always_comb begin
        key_dig    = key_digit(evt_key_q);
        hour_ok    = (entry_q[15:8] <= 8'h23) && (entry_q[15:12] <= 4'd2) && (entry_q[7:4] <= 4'd5);
        en_state_d = en_state_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        hour_d     = hour_q;
        min_d      = min_q;
        load_d     = 1'b0;
        if (evt_q) begin
            if (evt_key_q == KEY_STAR) begin
                entry_d    = 16'h0000;
                cnt_d      = 3'd0;
                err_d      = 1'b0;
                en_state_d = EN_IDLE;
            end else begin
                err_d = 1'b0;
                if (key_dig[4]) begin
                    if (en_state_q != EN_FULL) begin
                        entry_d    = {entry_q[11:0], key_dig[3:0]};
                        cnt_d      = cnt_q + 3'd1;
                        en_state_d = (cnt_q == 3'd3) ? EN_FULL : EN_ENTRY;
                    end
                end else if (evt_key_q == KEY_HASH) begin
                    if (en_state_q == EN_FULL && hour_ok) begin
                        hour_d     = entry_q[15:8];
                        min_d      = entry_q[7:0];
                        load_d     = 1'b1;
                        entry_d    = 16'h0000;
                        cnt_d      = 3'd0;
                        en_state_d = EN_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.Col      = ~(4'b0001 << col_q);
        bus.Hour     = hour_q;
        bus.Minutes  = min_q;
        bus.Load     = load_q;
        bus.Entry    = entry_q;
        bus.DigitCnt = cnt_q;
        bus.Error    = err_q;
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: a behavioural keypad drives the matrix, a queue of expected
// Hour/Minutes loads is compared whenever Load pulses.
module tb_keypad_time_entry;
    localparam int FRAME = 16;

    logic CP50 = 1'b0;
    logic nCR  = 1'b0;
    always #5 CP50 = ~CP50;

    keypad_time_entry_if kif();
    logic [15:0] keys_down = 16'h0000;

    // Pressed key shorts its row to its column while that column is strobed low.
    always_comb begin
        kif.Row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !kif.Col[c]) kif.Row[r] = 1'b0;
    end

    keypad_time_entry #(.CLK_Freq(16), .SCAN_Freq(4), .DEBOUNCE(2)) dut (
        .CP50 (CP50),
        .nCR  (nCR),
        .bus  (kif.master)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_loads = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sb_e;
    logic        prev_load = 1'b0;

    logic [15:0] m_entry = 16'h0000;
    int          m_cnt   = 0;
    logic        m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Key ids: 0-9 digits, 10 = '*', 11 = '#'; returns row*4+col.
    function automatic int key_pos(input int k);
        case (k)
            1: return 0;   2: return 1;   3: return 2;
            4: return 4;   5: return 5;   6: return 6;
            7: return 8;   8: return 9;   9: return 10;
            10: return 12; 0: return 13;  11: return 14;
            default: return 3;
        endcase
    endfunction

    task automatic hold(input int frames);
        repeat (frames * FRAME) @(posedge CP50);
    endtask

    task automatic model_key(input int k);
        if (k == 10) begin
            m_entry = 16'h0000; m_cnt = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (k <= 9) begin
                if (m_cnt < 4) begin
                    m_entry = {m_entry[11:0], 4'(k)};
                    m_cnt++;
                end
            end else if (m_cnt == 4 && m_entry[15:8] <= 8'h23 && m_entry[7:4] <= 4'd5) begin
                exp_q.push_back(m_entry);
                m_entry = 16'h0000; m_cnt = 0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge CP50);
        chk({tag, "_entry"}, kif.Entry, m_entry);
        chk({tag, "_cnt"}, kif.DigitCnt, m_cnt);
        chk({tag, "_err"}, kif.Error, m_err);
    endtask

    task automatic press(input int k);
        model_key(k);
        @(posedge CP50);
        keys_down = 16'h0001 << key_pos(k);
        hold(3);
        keys_down = 16'h0000;
        hold(3);
        check_state($sformatf("key%0d", k));
    endtask

    task automatic do_reset();
        @(negedge CP50);
        nCR = 1'b0;
        m_entry = 16'h0000; m_cnt = 0; m_err = 1'b0;
        #1;
        chk("rst_col", kif.Col, 4'b1110);
        chk("rst_hour", kif.Hour, 8'h00);
        chk("rst_min", kif.Minutes, 8'h00);
        chk("rst_load", kif.Load, 1'b0);
        chk("rst_entry", kif.Entry, 16'h0000);
        chk("rst_cnt", kif.DigitCnt, 3'd0);
        chk("rst_err", kif.Error, 1'b0);
        repeat (2) @(posedge CP50);
        @(negedge CP50);
        nCR = 1'b1;
    endtask

    always @(negedge CP50) begin
        if (kif.Load) begin
            n_loads++;
            chk("load_1cyc", prev_load, 1'b0);
            chk("load_expected", exp_q.size() > 0, 1'b1);
            chk("load_entry_clr", kif.Entry, 16'h0000);
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                chk("load_hour", kif.Hour, sb_e[15:8]);
                chk("load_min", kif.Minutes, sb_e[7:0]);
            end
        end
        prev_load = kif.Load;
    end

    initial begin
        repeat (3) @(posedge CP50);
        @(negedge CP50);
        nCR = 1'b1;
        repeat (7) @(posedge CP50);
        do_reset();

        press(1); press(2); press(3); press(4);
        chk("entry_1234", kif.Entry, 16'h1234);
        chk("cnt_full", kif.DigitCnt, 3'd4);
        press(11);

        press(2); press(5); press(0); press(0); press(11);
        chk("err_2500", kif.Error, 1'b1);
        chk("hold_2500", kif.Entry, 16'h2500);
        press(10);

        // Bouncing '5': isolated single-frame presses must not register.
        @(posedge CP50);
        for (int i = 0; i < 3; i++) begin
            keys_down = 16'h0001 << key_pos(5);
            hold(1);
            keys_down = 16'h0000;
            hold(1);
        end
        check_state("bounce");
        keys_down = 16'h0001 << key_pos(5);
        hold(2);
        keys_down = 16'h0000;
        hold(3);
        model_key(5);
        check_state("bounce_hold");
        press(10);

        // '1' and '4' share a column: two lows in one sample is rejected.
        @(posedge CP50);
        keys_down = (16'h0001 << key_pos(1)) | (16'h0001 << key_pos(4));
        hold(3);
        keys_down = 16'h0000;
        hold(3);
        check_state("ghost");

        press(1); press(0); press(11);
        chk("short_cnt", kif.DigitCnt, 3'd2);
        press(10);

        press(2); press(4); press(0); press(0); press(11);
        chk("err_hour24", kif.Error, 1'b1);
        press(10);

        press(2); press(3); press(5); press(9); press(1);
        chk("fifth_ignored", kif.Entry, 16'h2359);
        press(11);

        press(0); press(7);
        do_reset();
        press(0); press(0); press(0); press(0); press(11);

        hold(1);
        chk("load_count", n_loads, 3);
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
